// File: rtl/control_unit_pkg.sv
// Shared definitions for the instruction sequencer: widths, states, field offsets.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package control_unit_pkg;

    localparam int PC_W    = 8;   // program counter width
    localparam int INSTR_W = 15;  // instruction word width
    localparam int JT_W    = 6;   // jump-target field width

    // Instruction field offsets
    localparam int F_ALU_LSB  = 0;  // [3:0]  ALU select
    localparam int F_ALU_W    = 4;
    localparam int F_LD_B     = 4;  // [4]    register_b load
    localparam int F_LD_A     = 5;  // [5]    register_a load
    localparam int F_JMP      = 6;  // [6]    jump enable
    localparam int F_COND_LSB = 7;  // [8:7]  jump condition
    localparam int F_TGT_LSB  = 9;  // [14:9] jump target

    // An all-ones word stops the sequencer until reset.
    localparam logic [INSTR_W-1:0] HALT_INSTR = {INSTR_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_Z      = 2'b01,
        COND_N      = 2'b10,
        COND_C      = 2'b11
    } cond_t;

    // Packed so it maps directly onto the {c,n,z} flags bus.
    typedef struct packed {
        logic c;
        logic n;
        logic z;
    } flags_t;

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the sequencer and its datapath (instruction memory, ALU, PC, registers).
// Latency: n/a (wiring only).
// Backpressure: none; strobes are single-cycle commands, the datapath must accept them.
//   master: sequencer side (drives alu_s, load/PC strobes, step_done, halted, flags)
//   slave : datapath/environment side (drives run, step_req, instr, ALU flags)
interface control_unit_if;
    import control_unit_pkg::*;

    logic               run;
    logic               step_req;
    logic [INSTR_W-1:0] instr;
    logic               alu_z;
    logic               alu_n;
    logic               alu_c;

    logic [F_ALU_W-1:0] alu_s;
    logic               ld_a;
    logic               ld_b;
    logic               pc_inc;
    logic               pc_load;
    logic [PC_W-1:0]    pc_load_val;
    logic               step_done;
    logic               halted;
    logic [2:0]         flags;

    modport master (
        input  run, step_req, instr, alu_z, alu_n, alu_c,
        output alu_s, ld_a, ld_b, pc_inc, pc_load, pc_load_val,
               step_done, halted, flags
    );

    modport slave (
        output run, step_req, instr, alu_z, alu_n, alu_c,
        input  alu_s, ld_a, ld_b, pc_inc, pc_load, pc_load_val,
               step_done, halted, flags
    );

endinterface

// File: rtl/control_unit.sv
// Multi-cycle sequencer: FETCH latches the word, EXEC lets the ALU settle, WB fires strobes.
// Latency: 3 cycles per instruction; step_req -> step_done in 3 cycles.
// Backpressure: none; step_req outside IDLE is dropped, run is sampled only in IDLE and at WB.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : control_unit_if.master (run/step in, instr, ALU flags in; strobes, status out)
module control_unit
    import control_unit_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    control_unit_if.master bus
);

    state_t             state_q;
    logic [INSTR_W-1:0] instr_q;
    flags_t             flags_q;
    logic               run_mode_q;
    logic               ld_a_q;
    logic               ld_b_q;
    logic               pc_inc_q;
    logic               pc_load_q;
    logic               step_done_q;
    logic               halted_q;
    logic               take_jump;

    // Condition uses the flags captured by the previous WB, not the live ALU output.
    always_comb begin
        take_jump = 1'b0;
        if (instr_q[F_JMP]) begin
            case (cond_t'(instr_q[F_COND_LSB +: 2]))
                COND_ALWAYS: take_jump = 1'b1;
                COND_Z:      take_jump = flags_q.z;
                COND_N:      take_jump = flags_q.n;
                COND_C:      take_jump = flags_q.c;
                default:     take_jump = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            flags_q     <= '0;
            run_mode_q  <= 1'b0;
            ld_a_q      <= 1'b0;
            ld_b_q      <= 1'b0;
            pc_inc_q    <= 1'b0;
            pc_load_q   <= 1'b0;
            step_done_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            // Strobes are registered one cycle ahead (on EXEC->WB) so they are
            // high exactly during WB; default them low every other cycle.
            ld_a_q      <= 1'b0;
            ld_b_q      <= 1'b0;
            pc_inc_q    <= 1'b0;
            pc_load_q   <= 1'b0;
            step_done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.run || bus.step_req) begin
                        state_q    <= ST_FETCH;
                        run_mode_q <= bus.run;   // run wins when both are present
                    end
                end
                ST_FETCH: begin
                    instr_q <= bus.instr;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (instr_q == HALT_INSTR) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q     <= ST_WB;
                        ld_a_q      <= instr_q[F_LD_A];
                        ld_b_q      <= instr_q[F_LD_B];
                        pc_load_q   <= take_jump;
                        pc_inc_q    <= ~take_jump;
                        step_done_q <= ~run_mode_q;
                    end
                end
                ST_WB: begin
                    flags_q <= '{c: bus.alu_c, n: bus.alu_n, z: bus.alu_z};
                    state_q <= (run_mode_q && bus.run) ? ST_FETCH : ST_IDLE;
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // alu_s and the jump target come straight from the latched word, so they
    // hold their last value through IDLE and are zero after reset.
    assign bus.alu_s       = instr_q[F_ALU_LSB +: F_ALU_W];
    assign bus.pc_load_val = {{(PC_W-JT_W){1'b0}}, instr_q[F_TGT_LSB +: JT_W]};
    assign bus.ld_a        = ld_a_q;
    assign bus.ld_b        = ld_b_q;
    assign bus.pc_inc      = pc_inc_q;
    assign bus.pc_load     = pc_load_q;
    assign bus.step_done   = step_done_q;
    assign bus.halted      = halted_q;
    assign bus.flags       = flags_q;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: datapath environment, per-instruction reference model, scoreboard.
module tb_control_unit;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    control_unit_if bus ();

    control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- environment: program memory, PC, ALU ----------------
    logic [14:0] mem [256];
    logic [7:0]  env_pc;

    function automatic logic [2:0] alu_fn(input logic [3:0] s);
        // {c,n,z}: select 0 gives z=1, select 1 gives z=0 and c=1
        return {s[3] ^ s[0], s[2], (s[1:0] == 2'b00)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           env_pc <= 8'd0;
        else if (bus.pc_load) env_pc <= bus.pc_load_val;
        else if (bus.pc_inc)  env_pc <= env_pc + 8'd1;
    end

    assign bus.instr = mem[env_pc];
    assign {bus.alu_c, bus.alu_n, bus.alu_z} = alu_fn(bus.alu_s);

    // ---------------- reference model + scoreboard ----------------
    // Expected WB view: {ld_a, ld_b, pc_inc, pc_load, pc_load_val[7:0], step_done, alu_s[3:0], flags[2:0]}
    typedef struct {
        int          cyc;
        logic [19:0] v;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  ref_pc;
    logic [2:0]  ref_flags;   // {c,n,z} architecturally visible before the next instruction

    task automatic predict(input bit stepm, input int wb_cyc);
        logic [14:0] w;
        bit          take;
        exp_t        e;
        w = mem[ref_pc];
        case (w[8:7])
            2'b00:   take = 1'b1;
            2'b01:   take = ref_flags[0];
            2'b10:   take = ref_flags[1];
            default: take = ref_flags[2];
        endcase
        take  = take && w[6];
        e.cyc = wb_cyc;
        e.v   = {w[5], w[4], !take, take, {2'b00, w[14:9]}, stepm, w[3:0], ref_flags};
        exp_q.push_back(e);
        ref_flags = alu_fn(w[3:0]);
        ref_pc    = take ? {2'b00, w[14:9]} : ref_pc + 8'd1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe cycle must match the oldest pending expectation, at its cycle.
    always @(negedge clk) begin
        logic [19:0] act;
        exp_t        e;
        if (rst_n === 1'b1) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_wb expected at cyc %0d, no WB strobe observed (now %0d) expected=%h", e.cyc, cyc, e.v);
            end
            if (bus.ld_a || bus.ld_b || bus.pc_inc || bus.pc_load || bus.step_done) begin
                act = {bus.ld_a, bus.ld_b, bus.pc_inc, bus.pc_load, bus.pc_load_val,
                       bus.step_done, bus.alu_s, bus.flags};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe cyc=%0d got=%h expected no strobe", cyc, act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e.v || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL wb_event got=%h at cyc %0d expected=%h at cyc %0d", act, cyc, e.v, e.cyc);
                    end
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0; bus.run = 1'b0; bus.step_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ref_pc = 8'd0; ref_flags = 3'd0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 15'($urandom_range(0, 32'h7FFE));
    endtask

    // One single-step; optionally a second step_req during EXEC, optionally reset during WB.
    task automatic do_step(input bit extra, input bit rst_wb);
        int c;
        @(negedge clk); c = cyc;
        predict(1'b1, c + 3);
        bus.step_req = 1'b1;
        @(negedge clk); bus.step_req = 1'b0;
        @(negedge clk); if (extra) bus.step_req = 1'b1;
        @(negedge clk); bus.step_req = 1'b0;
        if (rst_wb) begin
            #1 rst_n = 1'b0;
            #1;
            chk("rst_wb_strobes", {27'd0, bus.ld_a, bus.ld_b, bus.pc_inc, bus.pc_load, bus.step_done}, 32'd0);
            chk("rst_wb_flags", {29'd0, bus.flags}, 32'd0);
            chk("rst_wb_alu_s_pcval", {20'd0, bus.alu_s, bus.pc_load_val}, 32'd0);
            chk("rst_wb_env_pc", {24'd0, env_pc}, 32'd0);
            @(negedge clk); rst_n = 1'b1;
            ref_pc = 8'd0; ref_flags = 3'd0;
        end else begin
            @(negedge clk);
        end
    endtask

    // Run n instructions; run is dropped in the FETCH/EXEC/WB (r=0/1/2) of the last one.
    task automatic do_run(input int n, input int r, input bit with_step);
        int c;
        @(negedge clk); c = cyc;
        for (int i = 0; i < n; i++) predict(1'b0, c + 3 + 3 * i);
        bus.run = 1'b1;
        if (with_step) bus.step_req = 1'b1;
        @(negedge clk); bus.step_req = 1'b0;
        repeat (3 * n - 3 + r) @(negedge clk);
        bus.run = 1'b0;
        repeat (c + 3 * n + 2 - cyc) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c;
        rst_n = 1'b0; bus.run = 1'b0; bus.step_req = 1'b0;
        ref_pc = 8'd0; ref_flags = 3'd0;
        fill_mem();
        repeat (2) @(negedge clk);
        chk("reset_strobes", {27'd0, bus.ld_a, bus.ld_b, bus.pc_inc, bus.pc_load, bus.step_done}, 32'd0);
        chk("reset_alu_s", {28'd0, bus.alu_s}, 32'd0);
        chk("reset_pc_load_val", {24'd0, bus.pc_load_val}, 32'd0);
        chk("reset_flags_halted", {28'd0, bus.flags, bus.halted}, 32'd0);
        rst_n = 1'b1;

        // Single step of 0x0031: strobes exactly on cycle 3 with step_done
        mem[0] = 15'h0031;
        do_step(1'b0, 1'b0);
        // step_req pulsed again in EXEC must be dropped
        do_step(1'b1, 1'b0);

        // Conditional jump on Z, target 5: taken with prior z=1, not taken with z=0
        reset_dut();
        mem[0] = 15'h0000; mem[1] = 15'h0AC1;
        do_step(1'b0, 1'b0); do_step(1'b0, 1'b0);
        chk("jmp_z_taken_pc", {24'd0, env_pc}, 32'd5);
        reset_dut();
        mem[0] = 15'h0001;
        do_step(1'b0, 1'b0); do_step(1'b0, 1'b0);
        chk("jmp_z_not_taken_pc", {24'd0, env_pc}, 32'd2);

        // Three non-jump instructions in run mode: WB every 3 cycles, no step_done
        for (int k = 0; k < 3; k++) mem[8'(ref_pc + 8'(k))][6] = 1'b0;
        do_run(3, 1, 1'b0);

        // Randomised mix of steps and run bursts over a random program
        reset_dut();
        fill_mem();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1)
                do_step(1'($urandom_range(0, 1)), 1'b0);
            else
                do_run($urandom_range(1, 6), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Reset during WB of a loading instruction, after flags were made nonzero
        mem[ref_pc] = 15'h0000;
        do_step(1'b0, 1'b0);
        mem[ref_pc] = 15'h0025;
        do_step(1'b0, 1'b1);
        // A step straight after reset proves the FSM is back in IDLE
        do_step(1'b0, 1'b0);

        // HALT under run: halted the cycle after EXEC, sticky, no strobes
        reset_dut();
        mem[0] = 15'h7FFF;
        @(negedge clk); c = cyc; bus.run = 1'b1;
        repeat (2) @(negedge clk);
        chk("halt_run_exec_cycle", {31'd0, bus.halted}, 32'd0);
        @(negedge clk);
        chk("halt_run_after_exec", {31'd0, bus.halted}, 32'd1);
        bus.step_req = 1'b1;
        repeat (2) @(negedge clk);
        bus.step_req = 1'b0; bus.run = 1'b0;
        repeat (3) @(negedge clk);
        bus.run = 1'b1;
        repeat (5) @(negedge clk);
        chk("halt_sticky", {31'd0, bus.halted}, 32'd1);
        chk("halt_pc_frozen", {24'd0, env_pc}, 32'd0);
        reset_dut();
        chk("halt_cleared_by_reset", {31'd0, bus.halted}, 32'd0);

        // HALT fetched during a step: halted, no step_done
        mem[0] = 15'h7FFF;
        @(negedge clk); bus.step_req = 1'b1;
        @(negedge clk); bus.step_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("halt_step", {31'd0, bus.halted}, 32'd1);
        repeat (4) @(negedge clk);
        reset_dut();
        repeat (2) @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
